// File: rtl/booth_mac_acc.sv
// Dot-product accumulator behind the 3-stage radix-4 Booth multiplier.
// Tags multiplier issue slots, accumulates with saturation, and queues results behind a credit check.

`timescale 1ns/1ps

module booth_mac_acc #(
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned OUT_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic             in_last_i,
   output logic             in_ready_o,
   input  logic [15:0]      prod_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [ACC_W-1:0] res_data_o,
   output logic             res_ovf_o
);

   // One tag stage per multiplier register plus the operand-sampling edge, so the tap lines up with prod_i.
   localparam int unsigned TAG_N = MUL_LAT + 1;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned CNT_W = $clog2(OUT_DEPTH + TAG_N + 1);
   localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [TAG_N-1:0]        tag_v_q, tag_v_d;
   logic [TAG_N-1:0]        tag_l_q, tag_l_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    first_q, first_d;
   logic                    ovf_q, ovf_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic                    in_ready_q, in_ready_d;

   logic [ACC_W-1:0]        fifo_data_q [OUT_DEPTH];
   logic                    fifo_ovf_q  [OUT_DEPTH];

   logic                    accept;
   logic                    tap_v;
   logic                    tap_l;
   logic                    push;
   logic                    pop;
   logic                    fifo_nonempty;
   logic [ACC_W-1:0]        base;
   logic signed [SUM_W-1:0] sum_w;
   logic                    beat_ovf;
   logic [ACC_W-1:0]        sat_sum;
   logic                    push_ovf;
   logic [CNT_W-1:0]        pend_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign accept        = in_valid_i & in_ready_q;
   assign tap_v         = tag_v_q[TAG_N-1];
   assign tap_l         = tag_l_q[TAG_N-1];
   assign fifo_nonempty = (cnt_q != '0);
   assign push          = tap_v & tap_l;
   assign pop           = fifo_nonempty & res_ready_i;

   // Saturating add; a first beat starts from zero so the previous dot product never leaks in.
   always_comb begin
      base     = first_q ? '0 : acc_q;
      sum_w    = SUM_W'($signed(base)) + SUM_W'($signed(prod_i));
      beat_ovf = sum_w[SUM_W-1] ^ sum_w[SUM_W-2];
      sat_sum  = sum_w[ACC_W-1:0];
      if (beat_ovf) begin
         sat_sum = sum_w[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end
      push_ovf = ovf_q | beat_ovf;
   end

   // Next-state for tags, accumulator, FIFO pointers and the issue credit.
   always_comb begin
      tag_v_d    = {tag_v_q[TAG_N-2:0], accept};
      tag_l_d    = {tag_l_q[TAG_N-2:0], in_last_i};
      acc_d      = acc_q;
      first_d    = first_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      pend_d     = '0;
      in_ready_d = 1'b0;

      if (tap_v) begin
         if (tap_l) begin
            acc_d   = '0;
            first_d = 1'b1;
            ovf_d   = 1'b0;
         end else begin
            acc_d   = sat_sum;
            first_d = 1'b0;
            ovf_d   = push_ovf;
         end
      end

      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      // Every in-flight last beat reserves a FIFO slot before it is allowed in.
      for (int unsigned i = 0; i < TAG_N; i++) begin
         pend_d = pend_d + CNT_W'(tag_v_d[i] & tag_l_d[i]);
      end
      in_ready_d = (cnt_d + pend_d) < CNT_W'(OUT_DEPTH);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_v_q    <= '0;
         tag_l_q    <= '0;
         acc_q      <= '0;
         first_q    <= 1'b1;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         in_ready_q <= 1'b1;
      end else begin
         tag_v_q    <= tag_v_d;
         tag_l_q    <= tag_l_d;
         acc_q      <= acc_d;
         first_q    <= first_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Payload storage needs no reset: emptiness is tracked by cnt_q alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= sat_sum;
         fifo_ovf_q[wr_ptr_q]  <= push_ovf;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign res_valid_o = fifo_nonempty;
   assign res_data_o  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
   assign res_ovf_o   = fifo_nonempty ? fifo_ovf_q[rd_ptr_q] : 1'b0;

   push_never_full_a : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (cnt_q == CNT_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: directed vectors, expectations queued at issue, results checked by monitors.
// Instance A: ACC_W=24, OUT_DEPTH=2. Instance B: ACC_W=17, OUT_DEPTH=6 (never back-pressures at full rate).

`timescale 1ns/1ps

module tb_booth_mac_acc;

   typedef struct {
      int   data;
      logic ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic in_valid  [2];
   logic in_last   [2];
   logic res_ready [2];
   logic signed [7:0]  md [2];
   logic signed [7:0]  mr [2];
   logic signed [15:0] pp [2][4];

   logic        rdy_a, rdy_b, vld_a, vld_b, ovf_a, ovf_b;
   logic [23:0] data_a;
   logic [16:0] data_b;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   booth_mac_acc #(.MUL_LAT(3), .ACC_W(24), .OUT_DEPTH(2)) u_a (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid[0]), .in_last_i(in_last[0]), .in_ready_o(rdy_a),
      .prod_i(pp[0][3]),
      .res_valid_o(vld_a), .res_ready_i(res_ready[0]),
      .res_data_o(data_a), .res_ovf_o(ovf_a)
   );

   booth_mac_acc #(.MUL_LAT(3), .ACC_W(17), .OUT_DEPTH(6)) u_b (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid[1]), .in_last_i(in_last[1]), .in_ready_o(rdy_b),
      .prod_i(pp[1][3]),
      .res_valid_o(vld_b), .res_ready_i(res_ready[1]),
      .res_data_o(data_b), .res_ovf_o(ovf_b)
   );

   // Multiplier stand-in: operands sampled at an edge, product visible MUL_LAT edges later.
   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         pp[s][0] <= 16'(md[s]) * 16'(mr[s]);
         for (int k = 1; k < 4; k++) pp[s][k] <= pp[s][k-1];
      end
   end

   task automatic check(input string name, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic logic rdy(input int s);
      return (s == 0) ? rdy_a : rdy_b;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input int s, input int d, input logic o);
      exp_t e;
      e.data = d;
      e.ovf  = o;
      if (s == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   // Hold a beat until the edge that accepts it; leaves the phase at 1 ns after that edge.
   task automatic issue(input int s, input int a, input int b, input logic last);
      int   waited = 0;
      logic ok;
      in_valid[s] = 1'b1;
      in_last[s]  = last;
      md[s]       = 8'(a);
      mr[s]       = 8'(b);
      do begin
         ok = rdy(s);
         @(posedge clk);
         #1;
         waited++;
      end while (!ok && waited < 50);
      check("issue_accepted", int'(ok), 1);
      in_valid[s] = 1'b0;
      in_last[s]  = 1'($urandom_range(0, 1));
      md[s]       = 8'sh5A;
      mr[s]       = 8'sh33;
   endtask

   always @(negedge clk) begin
      if (!rst && vld_a && res_ready[0]) begin
         check("a_result_expected", int'(q_a.size() > 0), 1);
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("a_data", int'($signed(data_a)), ea.data);
            check("a_ovf", int'(ovf_a), int'(ea.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && vld_b && res_ready[1]) begin
         check("b_result_expected", int'(q_b.size() > 0), 1);
         if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("b_data", int'($signed(data_b)), eb.data);
            check("b_ovf", int'(ovf_b), int'(eb.ovf));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         in_last[s]   = 1'b0;
         res_ready[s] = 1'b0;
         md[s]        = 8'sh5A;
         mr[s]        = 8'sh33;
      end
      #3;
      check("rst_a_valid", int'(vld_a), 0);
      check("rst_a_data", int'(data_a), 0);
      check("rst_a_ovf", int'(ovf_a), 0);
      check("rst_a_ready", int'(rdy_a), 1);
      check("rst_b_valid", int'(vld_b), 0);
      check("rst_b_ready", int'(rdy_b), 1);
      @(posedge clk);
      #4 rst = 1'b0;
      @(posedge clk);
      #1;
      res_ready[0] = 1'b1;
      res_ready[1] = 1'b1;

      // 1: single beat 3*5, result four edges after accept
      expect_res(0, 15, 1'b0);
      issue(0, 3, 5, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("t1_not_yet_valid", int'(vld_a), 0);
      end
      @(posedge clk);
      #1;
      check("t1_valid_at_4", int'(vld_a), 1);
      check("t1_data_at_4", int'($signed(data_a)), 15);
      idle(3);

      // 2: four beats of (-128)*(-128) -> 65536, nothing before the last beat lands
      expect_res(0, 65536, 1'b0);
      repeat (3) issue(0, -128, -128, 1'b0);
      issue(0, -128, -128, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("t2_no_early_result", int'(vld_a), 0);
      end
      idle(4);

      // 3: 17-bit accumulator saturates, next dot product starts clean
      expect_res(1, 65535, 1'b1);
      repeat (3) issue(1, -128, -128, 1'b0);
      issue(1, -128, -128, 1'b1);
      expect_res(1, 6, 1'b0);
      issue(1, 2, 3, 1'b1);
      idle(8);

      // 4: credit back-pressure with consumer stalled
      res_ready[0] = 1'b0;
      expect_res(0, 1, 1'b0);
      expect_res(0, 4, 1'b0);
      expect_res(0, 9, 1'b0);
      issue(0, 1, 1, 1'b1);
      issue(0, 2, 2, 1'b1);
      check("t4_ready_low_after_2nd", int'(rdy_a), 0);
      fork
         issue(0, 3, 3, 1'b1);
         begin
            repeat (6) @(posedge clk);
            #2;
            check("t4_ready_still_low", int'(rdy_a), 0);
            check("t4_head_valid", int'(vld_a), 1);
            check("t4_head_stable", int'($signed(data_a)), 1);
            res_ready[0] = 1'b1;
         end
      join
      idle(8);
      check("t4_ready_restored", int'(rdy_a), 1);

      // 5: full-rate single-beat stream with two bubbles
      for (int i = 0; i < 20; i++) begin
         if (i == 5 || i == 11) begin
            in_valid[1] = 1'b0;
            idle(1);
         end else begin
            check("t5_ready_high", int'(rdy_b), 1);
            expect_res(1, i, 1'b0);
            issue(1, i, 1, 1'b1);
         end
      end
      idle(8);

      // 6: reset with a queued result and a partial sum in flight
      res_ready[0] = 1'b0;
      issue(0, 5, 5, 1'b1);
      issue(0, 10, 10, 1'b0);
      issue(0, 10, 10, 1'b0);
      idle(4);
      check("t6_pre_valid", int'(vld_a), 1);
      check("t6_pre_data", int'($signed(data_a)), 25);
      #3 rst = 1'b1;
      #1;
      check("t6_rst_valid", int'(vld_a), 0);
      check("t6_rst_data", int'(data_a), 0);
      check("t6_rst_ovf", int'(ovf_a), 0);
      check("t6_rst_ready", int'(rdy_a), 1);
      @(posedge clk);
      #4 rst = 1'b0;
      @(posedge clk);
      #1;
      res_ready[0] = 1'b1;
      check("t6_post_empty", int'(vld_a), 0);
      expect_res(0, 49, 1'b0);
      issue(0, 7, 7, 1'b1);
      idle(10);

      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
